// File: rtl/pcie_dn_cpld_dfk_mc_if.sv
// Completion-beat input, free-buffer output and file-header handshake bundle
// for the multi-channel downstream descriptor unpacker.
interface pcie_dn_cpld_dfk_mc_if #(
  parameter int DW  = 64,
  parameter int CHW = 2
);
  logic           DFK_CP_SOP;
  logic           DFK_CP_EOP;
  logic [DW-1:0]  DFK_CP_DATA;
  logic           DFK_CP_DVLD;
  logic [7:0]     DFK_CP_TAG;
  logic [11:0]    DFK_CP_DCNT;
  logic           DN_FBUF_WR_REQ;
  logic [95:0]    DN_FBUF_WR_DATA;
  logic [CHW-1:0] DN_FBUF_WR_CH;
  logic           DN_FBUF_RD_REQ;
  logic           DN_FBUF_RD_ACK;
  logic [CHW-1:0] DN_FBUF_RD_CH;
  logic           DN_FILE_VLD;
  logic           DN_FILE_RDY;
  logic           DN_FILE_SOF;
  logic           DN_FILE_EOF;
  logic [15:0]    DN_FILE_FID;
  logic [15:0]    DN_FILE_SID;
  logic [15:0]    DN_FILE_VCH;
  logic [31:0]    DN_FILE_ADDR;
  logic [31:0]    DN_FILE_SIZE;
  logic [CHW-1:0] DN_FILE_CH;
  logic [15:0]    STAT_ERR_CNT;
  logic [15:0]    STAT_OVF_CNT;

  modport master (
    output DFK_CP_SOP, DFK_CP_EOP, DFK_CP_DATA, DFK_CP_DVLD, DFK_CP_TAG, DFK_CP_DCNT,
           DN_FILE_RDY,
    input  DN_FBUF_WR_REQ, DN_FBUF_WR_DATA, DN_FBUF_WR_CH, DN_FBUF_RD_REQ, DN_FBUF_RD_ACK,
           DN_FBUF_RD_CH, DN_FILE_VLD, DN_FILE_SOF, DN_FILE_EOF, DN_FILE_FID, DN_FILE_SID,
           DN_FILE_VCH, DN_FILE_ADDR, DN_FILE_SIZE, DN_FILE_CH, STAT_ERR_CNT, STAT_OVF_CNT
  );

  modport slave (
    input  DFK_CP_SOP, DFK_CP_EOP, DFK_CP_DATA, DFK_CP_DVLD, DFK_CP_TAG, DFK_CP_DCNT,
           DN_FILE_RDY,
    output DN_FBUF_WR_REQ, DN_FBUF_WR_DATA, DN_FBUF_WR_CH, DN_FBUF_RD_REQ, DN_FBUF_RD_ACK,
           DN_FBUF_RD_CH, DN_FILE_VLD, DN_FILE_SOF, DN_FILE_EOF, DN_FILE_FID, DN_FILE_SID,
           DN_FILE_VCH, DN_FILE_ADDR, DN_FILE_SIZE, DN_FILE_CH, STAT_ERR_CNT, STAT_OVF_CNT
  );
endinterface

// File: rtl/pcie_dn_cpld_dfk_mc.sv
// Multi-channel CplD descriptor unpacker: per-tag 256-bit assembly, free-buffer
// entries, grouped RD_REQ/RD_ACK pulses and a first-word-fall-through header FIFO.
module pcie_dn_cpld_dfk_mc #(
  parameter int DW           = 64,
  parameter int NCH          = 4,
  parameter int DESC_PER_ACK = 8,
  parameter int ACK_DLY      = 4,
  parameter int HDR_DEPTH    = 4
) (
  input logic PCIE_CLK,
  input logic PCIE_RST_N,
  pcie_dn_cpld_dfk_mc_if.slave bus
);
  localparam int BEATS = 256 / DW;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BCW   = $clog2(BEATS) + 1;
  localparam int GCW   = $clog2(DESC_PER_ACK);
  localparam int AW    = $clog2(HDR_DEPTH);
  localparam int HW    = 114 + CHW;

  logic [CHW-1:0] ch;
  logic           ch_ok, acc, done, err;
  logic [BCW-1:0] cnt_cur, cnt_nxt;
  logic [255:0]   shifted;
  logic [BCW-1:0] bcnt [NCH];
  logic [GCW-1:0] gcnt [NCH];
  logic [255:0]   desc_q;
  logic           desc_vld, grp_done;
  logic [CHW-1:0] desc_ch;
  logic [15:0]    err_cnt, ovf_cnt;

  logic           wr_req;
  logic [95:0]    wr_data;
  logic [CHW-1:0] wr_ch;
  logic [ACK_DLY-1:0] ack_sr, req_sr;
  logic [CHW-1:0] ch_sr [ACK_DLY];

  logic [HW-1:0]  mem [HDR_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  logic [HW-1:0]  hdr_in;

  assign ch      = bus.DFK_CP_TAG[CHW-1:0];
  assign ch_ok   = ({1'b0, ch} < (CHW+1)'(NCH));
  assign acc     = bus.DFK_CP_DVLD && ch_ok;
  assign cnt_cur = ch_ok ? bcnt[ch] : '0;
  assign cnt_nxt = bus.DFK_CP_SOP ? BCW'(1) : cnt_cur + 1'b1;
  assign done    = acc && (cnt_nxt == BCW'(BEATS));
  assign err     = acc && ((bus.DFK_CP_SOP && (cnt_cur != '0)) || (bus.DFK_CP_EOP && !done));

  // Only the upper 256-DW bits of a partial descriptor need storing; the
  // current beat supplies the rest, so a full-width beat needs no storage.
  generate
    if (BEATS == 1) begin : g_nosr
      assign shifted = bus.DFK_CP_DATA;
    end else begin : g_sr
      logic [255-DW:0] sreg [NCH];
      logic [255-DW:0] sreg_cur;
      assign sreg_cur = ch_ok ? sreg[ch] : '0;
      assign shifted  = {bus.DFK_CP_DATA, sreg_cur};
      always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
        if (!PCIE_RST_N) begin
          for (int i = 0; i < NCH; i++) sreg[i] <= '0;
        end else if (acc) begin
          sreg[ch] <= shifted[255:DW];
        end
      end
    end
  endgenerate

  always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
    if (!PCIE_RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        bcnt[i] <= '0;
        gcnt[i] <= '0;
      end
      desc_q   <= '0;
      desc_vld <= 1'b0;
      desc_ch  <= '0;
      grp_done <= 1'b0;
      err_cnt  <= '0;
    end else begin
      desc_vld <= done;
      // EOP either completes the descriptor or aborts it; both leave the counter idle.
      if (acc) bcnt[ch] <= (done || bus.DFK_CP_EOP) ? '0 : cnt_nxt;
      if (done) begin
        desc_q   <= shifted;
        desc_ch  <= ch;
        grp_done <= (gcnt[ch] == GCW'(DESC_PER_ACK - 1));
        gcnt[ch] <= gcnt[ch] + 1'b1;
      end
      if (err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push   = desc_vld && (desc_q[127] || desc_q[126]);
  assign pop    = !empty && bus.DN_FILE_RDY;
  assign hdr_in = {desc_ch, desc_q[127], desc_q[126], desc_q[159:144], desc_q[143:128],
                   desc_q[95:80], desc_q[223:192], desc_q[191:160]};

  always_ff @(posedge PCIE_CLK or negedge PCIE_RST_N) begin
    if (!PCIE_RST_N) begin
      wr_req  <= 1'b0;
      wr_data <= '0;
      wr_ch   <= '0;
      ack_sr  <= '0;
      req_sr  <= '0;
      for (int i = 0; i < ACK_DLY; i++) ch_sr[i] <= '0;
      for (int i = 0; i < HDR_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_cnt <= '0;
    end else begin
      wr_req <= desc_vld && desc_q[120];
      if (desc_vld && desc_q[120]) begin
        wr_data <= {desc_q[111:96], desc_q[79:64], desc_q[63:0]};
        wr_ch   <= desc_ch;
      end
      for (int i = ACK_DLY - 1; i > 0; i--) begin
        ack_sr[i] <= ack_sr[i-1];
        req_sr[i] <= req_sr[i-1];
        ch_sr[i]  <= ch_sr[i-1];
      end
      ack_sr[0] <= desc_vld && grp_done;
      req_sr[0] <= desc_vld && grp_done && desc_q[121];
      if (desc_vld && grp_done) ch_sr[0] <= desc_ch;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (push && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= hdr_in;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (push && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.DN_FBUF_WR_REQ  = wr_req;
  assign bus.DN_FBUF_WR_DATA = wr_data;
  assign bus.DN_FBUF_WR_CH   = wr_ch;
  assign bus.DN_FBUF_RD_ACK  = ack_sr[ACK_DLY-1];
  assign bus.DN_FBUF_RD_REQ  = req_sr[ACK_DLY-1];
  assign bus.DN_FBUF_RD_CH   = ch_sr[ACK_DLY-1];
  assign bus.DN_FILE_VLD     = !empty;
  assign {bus.DN_FILE_CH, bus.DN_FILE_SOF, bus.DN_FILE_EOF, bus.DN_FILE_FID, bus.DN_FILE_SID,
          bus.DN_FILE_VCH, bus.DN_FILE_ADDR, bus.DN_FILE_SIZE} = mem[rd_ptr[AW-1:0]];
  assign bus.STAT_ERR_CNT    = err_cnt;
  assign bus.STAT_OVF_CNT    = ovf_cnt;

  logic unused_bits;
  assign unused_bits = ^{bus.DFK_CP_DCNT, bus.DFK_CP_TAG[7:CHW], desc_q[255:224],
                         desc_q[125:122], desc_q[119:112]};
endmodule

// File: tb/tb_pcie_dn_cpld_dfk_mc.sv
// Directed bench for the multi-channel CplD unpacker: a DW=64/NCH=4 instance
// plus a DW=128/NCH=1 instance for the wide-beat header case.
module tb_pcie_dn_cpld_dfk_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   wr_seen = 0;
  int   rd_seen = 0;

  always #5 clk = ~clk;

  pcie_dn_cpld_dfk_mc_if #(.DW(64),  .CHW(2)) b ();
  pcie_dn_cpld_dfk_mc_if #(.DW(128), .CHW(1)) b2 ();

  pcie_dn_cpld_dfk_mc #(.DW(64), .NCH(4), .DESC_PER_ACK(8), .ACK_DLY(4), .HDR_DEPTH(4)) dut (
    .PCIE_CLK(clk), .PCIE_RST_N(rst_n), .bus(b.slave));

  pcie_dn_cpld_dfk_mc #(.DW(128), .NCH(1), .DESC_PER_ACK(8), .ACK_DLY(4), .HDR_DEPTH(4)) dut2 (
    .PCIE_CLK(clk), .PCIE_RST_N(rst_n), .bus(b2.slave));

  always @(negedge clk) begin
    if (b.DN_FBUF_WR_REQ === 1'b1) wr_seen++;
    if (b.DN_FBUF_RD_ACK === 1'b1) rd_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] tag, input logic sop, input logic eop, input logic [63:0] d);
    b.DFK_CP_DVLD = 1'b1;
    b.DFK_CP_SOP  = sop;
    b.DFK_CP_EOP  = eop;
    b.DFK_CP_TAG  = tag;
    b.DFK_CP_DATA = d;
    b.DFK_CP_DCNT = 12'd8;
    tick();
    b.DFK_CP_DVLD = 1'b0;
    b.DFK_CP_SOP  = 1'b0;
    b.DFK_CP_EOP  = 1'b0;
  endtask

  task automatic send_desc(input logic [7:0] tag, input logic [255:0] d);
    for (int i = 0; i < 4; i++) beat(tag, i == 0, i == 3, d[64*i +: 64]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b0) begin n_bad++; $display("FAIL rst_wr_req got %0h want 0", b.DN_FBUF_WR_REQ); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'h0) begin n_bad++; $display("FAIL rst_wr_data got %h want 0", b.DN_FBUF_WR_DATA); end
    n_vec++; if (b.DN_FILE_VLD !== 1'b0) begin n_bad++; $display("FAIL rst_file_vld got %0h want 0", b.DN_FILE_VLD); end
    n_vec++; if (b.STAT_ERR_CNT !== 16'h0) begin n_bad++; $display("FAIL rst_err_cnt got %0h want 0", b.STAT_ERR_CNT); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [255:0] d;
    d = '0;
    d[63:0]   = 64'h1122334455667788;
    d[79:64]  = 16'hCAFE;
    d[111:96] = 16'hBEEF;
    d[120]    = 1'b1;
    send_desc(8'h02, d);
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b0) begin n_bad++; $display("FAIL single_early got %0h want 0", b.DN_FBUF_WR_REQ); end
    tick();
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b1) begin n_bad++; $display("FAIL single_wr_req got %0h want 1", b.DN_FBUF_WR_REQ); end
    n_vec++; if (b.DN_FBUF_WR_CH !== 2'd2) begin n_bad++; $display("FAIL single_wr_ch got %0h want 2", b.DN_FBUF_WR_CH); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'hBEEF_CAFE_1122334455667788) begin n_bad++; $display("FAIL single_wr_data got %h want beefcafe1122334455667788", b.DN_FBUF_WR_DATA); end
    tick();
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b0) begin n_bad++; $display("FAIL single_pulse got %0h want 0", b.DN_FBUF_WR_REQ); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'hBEEF_CAFE_1122334455667788) begin n_bad++; $display("FAIL single_hold got %h want beefcafe1122334455667788", b.DN_FBUF_WR_DATA); end
    n_vec++; if (b.DN_FILE_VLD !== 1'b0) begin n_bad++; $display("FAIL single_no_hdr got %0h want 0", b.DN_FILE_VLD); end
    n_vec++; if (b.STAT_ERR_CNT !== 16'h0) begin n_bad++; $display("FAIL single_err got %0h want 0", b.STAT_ERR_CNT); end
  endtask

  task automatic test_group();
    logic [255:0] d0, d1;
    int base_rd, base_wr;
    base_rd = rd_seen;
    base_wr = wr_seen;
    for (int k = 0; k < 7; k++) begin
      d1 = '0; d1[63:0] = 64'h1000 + 64'(k); d1[120] = 1'b1;
      d0 = '0; d0[63:0] = 64'h2000 + 64'(k); d0[120] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        beat(8'h01, i == 0, i == 3, d1[64*i +: 64]);
        beat(8'h00, i == 0, i == 3, d0[64*i +: 64]);
      end
    end
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (rd_seen - base_rd !== 0) begin n_bad++; $display("FAIL grp_no_early_ack got %0d want 0", rd_seen - base_rd); end
    n_vec++; if (wr_seen - base_wr !== 14) begin n_bad++; $display("FAIL grp_wr_count got %0d want 14", wr_seen - base_wr); end
    d1 = '0; d1[63:0] = 64'h1007; d1[120] = 1'b1; d1[121] = 1'b1;
    send_desc(8'h01, d1);
    tick();
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b1) begin n_bad++; $display("FAIL grp_wr8 got %0h want 1", b.DN_FBUF_WR_REQ); end
    tick(); tick();
    n_vec++; if (b.DN_FBUF_RD_ACK !== 1'b0) begin n_bad++; $display("FAIL grp_ack_early got %0h want 0", b.DN_FBUF_RD_ACK); end
    tick();
    n_vec++; if (b.DN_FBUF_RD_ACK !== 1'b1) begin n_bad++; $display("FAIL grp_ack got %0h want 1", b.DN_FBUF_RD_ACK); end
    n_vec++; if (b.DN_FBUF_RD_REQ !== 1'b1) begin n_bad++; $display("FAIL grp_req got %0h want 1", b.DN_FBUF_RD_REQ); end
    n_vec++; if (b.DN_FBUF_RD_CH !== 2'd1) begin n_bad++; $display("FAIL grp_ch got %0h want 1", b.DN_FBUF_RD_CH); end
    tick();
    n_vec++; if (b.DN_FBUF_RD_ACK !== 1'b0) begin n_bad++; $display("FAIL grp_ack_pulse got %0h want 0", b.DN_FBUF_RD_ACK); end
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (rd_seen - base_rd !== 1) begin n_bad++; $display("FAIL grp_ack_total got %0d want 1", rd_seen - base_rd); end
  endtask

  task automatic test_hdr_ovf();
    logic [255:0] d;
    b.DN_FILE_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = '0; d[127] = 1'b1; d[159:144] = 16'h00A0 + 16'(i);
      send_desc(8'h02, d);
    end
    tick(); tick();
    n_vec++; if (b.DN_FILE_VLD !== 1'b1) begin n_bad++; $display("FAIL hdr_vld got %0h want 1", b.DN_FILE_VLD); end
    n_vec++; if (b.DN_FILE_SOF !== 1'b1) begin n_bad++; $display("FAIL hdr_sof got %0h want 1", b.DN_FILE_SOF); end
    n_vec++; if (b.DN_FILE_CH !== 2'd2) begin n_bad++; $display("FAIL hdr_ch got %0h want 2", b.DN_FILE_CH); end
    n_vec++; if (b.STAT_OVF_CNT !== 16'd1) begin n_bad++; $display("FAIL hdr_ovf got %0h want 1", b.STAT_OVF_CNT); end
    b.DN_FILE_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (b.DN_FILE_VLD !== 1'b1) begin n_bad++; $display("FAIL hdr_pop_vld%0d got %0h want 1", i, b.DN_FILE_VLD); end
      n_vec++; if (b.DN_FILE_FID !== 16'h00A0 + 16'(i)) begin n_bad++; $display("FAIL hdr_fid%0d got %h want %h", i, b.DN_FILE_FID, 16'h00A0 + 16'(i)); end
      tick();
    end
    n_vec++; if (b.DN_FILE_VLD !== 1'b0) begin n_bad++; $display("FAIL hdr_empty got %0h want 0", b.DN_FILE_VLD); end
    b.DN_FILE_RDY = 1'b0;
  endtask

  task automatic test_errors();
    logic [255:0] d;
    int base_wr;
    base_wr = wr_seen;
    beat(8'h03, 1'b1, 1'b0, 64'hDEAD_0000_0000_0001);
    beat(8'h03, 1'b0, 1'b1, 64'hDEAD_0000_0000_0002);
    d = '0; d[63:0] = 64'hA5A5A5A5A5A5A5A5; d[79:64] = 16'h5678; d[111:96] = 16'h1234; d[120] = 1'b1;
    send_desc(8'h03, d);
    tick(); tick(); tick();
    n_vec++; if (b.STAT_ERR_CNT !== 16'd1) begin n_bad++; $display("FAIL eop_err got %0h want 1", b.STAT_ERR_CNT); end
    n_vec++; if (wr_seen - base_wr !== 1) begin n_bad++; $display("FAIL eop_wr_count got %0d want 1", wr_seen - base_wr); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'h1234_5678_A5A5A5A5A5A5A5A5) begin n_bad++; $display("FAIL eop_wr_data got %h want 12345678a5a5a5a5a5a5a5a5", b.DN_FBUF_WR_DATA); end
    n_vec++; if (b.DN_FBUF_WR_CH !== 2'd3) begin n_bad++; $display("FAIL eop_wr_ch got %0h want 3", b.DN_FBUF_WR_CH); end
    beat(8'h03, 1'b1, 1'b0, 64'hDEAD_0000_0000_0003);
    beat(8'h03, 1'b0, 1'b0, 64'hDEAD_0000_0000_0004);
    d = '0; d[63:0] = 64'h0F0F0F0F0F0F0F0F; d[120] = 1'b1;
    send_desc(8'h03, d);
    tick(); tick();
    n_vec++; if (b.STAT_ERR_CNT !== 16'd2) begin n_bad++; $display("FAIL sop_err got %0h want 2", b.STAT_ERR_CNT); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'h0000_0000_0F0F0F0F0F0F0F0F) begin n_bad++; $display("FAIL sop_wr_data got %h want 0f0f0f0f0f0f0f0f", b.DN_FBUF_WR_DATA); end
    beat(8'h03, 1'b1, 1'b0, 64'hDEAD_0000_0000_0005);
    beat(8'h03, 1'b1, 1'b1, 64'hDEAD_0000_0000_0006);
    tick();
    n_vec++; if (b.STAT_ERR_CNT !== 16'd3) begin n_bad++; $display("FAIL both_err got %0h want 3", b.STAT_ERR_CNT); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    beat(8'h02, 1'b1, 1'b0, 64'h1111);
    beat(8'h02, 1'b0, 1'b0, 64'h2222);
    beat(8'h02, 1'b0, 1'b0, 64'h3333);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'h0) begin n_bad++; $display("FAIL mrst_wr_data got %h want 0", b.DN_FBUF_WR_DATA); end
    n_vec++; if (b.DN_FBUF_WR_CH !== 2'd0) begin n_bad++; $display("FAIL mrst_wr_ch got %0h want 0", b.DN_FBUF_WR_CH); end
    n_vec++; if (b.STAT_ERR_CNT !== 16'd0) begin n_bad++; $display("FAIL mrst_err got %0h want 0", b.STAT_ERR_CNT); end
    n_vec++; if (b.STAT_OVF_CNT !== 16'd0) begin n_bad++; $display("FAIL mrst_ovf got %0h want 0", b.STAT_OVF_CNT); end
    n_vec++; if (b.DN_FBUF_RD_CH !== 2'd0) begin n_bad++; $display("FAIL mrst_rd_ch got %0h want 0", b.DN_FBUF_RD_CH); end
    tick();
    rst_n = 1'b1;
    tick();
    d = '0; d[63:0] = 64'h0BADF00D_CAFEF00D; d[120] = 1'b1;
    send_desc(8'h02, d);
    tick();
    n_vec++; if (b.DN_FBUF_WR_REQ !== 1'b1) begin n_bad++; $display("FAIL mrst_wr_req got %0h want 1", b.DN_FBUF_WR_REQ); end
    n_vec++; if (b.DN_FBUF_WR_DATA !== 96'h0000_0000_0BADF00D_CAFEF00D) begin n_bad++; $display("FAIL mrst_data got %h want 0badf00dcafef00d", b.DN_FBUF_WR_DATA); end
    n_vec++; if (b.STAT_ERR_CNT !== 16'd0) begin n_bad++; $display("FAIL mrst_err_after got %0h want 0", b.STAT_ERR_CNT); end
  endtask

  task automatic test_dw128();
    logic [255:0] d;
    d = '0; d[126] = 1'b1; d[191:160] = 32'h0000_1000; d[223:192] = 32'h8000_0000;
    b2.DN_FILE_RDY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b2.DFK_CP_DVLD = 1'b1;
      b2.DFK_CP_SOP  = (i == 0);
      b2.DFK_CP_EOP  = (i == 1);
      b2.DFK_CP_TAG  = 8'h00;
      b2.DFK_CP_DATA = d[128*i +: 128];
      tick();
    end
    b2.DFK_CP_DVLD = 1'b0; b2.DFK_CP_SOP = 1'b0; b2.DFK_CP_EOP = 1'b0;
    n_vec++; if (b2.DN_FILE_VLD !== 1'b0) begin n_bad++; $display("FAIL w128_early got %0h want 0", b2.DN_FILE_VLD); end
    tick();
    n_vec++; if (b2.DN_FILE_VLD !== 1'b1) begin n_bad++; $display("FAIL w128_vld got %0h want 1", b2.DN_FILE_VLD); end
    n_vec++; if (b2.DN_FILE_EOF !== 1'b1) begin n_bad++; $display("FAIL w128_eof got %0h want 1", b2.DN_FILE_EOF); end
    n_vec++; if (b2.DN_FILE_SOF !== 1'b0) begin n_bad++; $display("FAIL w128_sof got %0h want 0", b2.DN_FILE_SOF); end
    n_vec++; if (b2.DN_FILE_SIZE !== 32'h0000_1000) begin n_bad++; $display("FAIL w128_size got %h want 00001000", b2.DN_FILE_SIZE); end
    n_vec++; if (b2.DN_FILE_ADDR !== 32'h8000_0000) begin n_bad++; $display("FAIL w128_addr got %h want 80000000", b2.DN_FILE_ADDR); end
    n_vec++; if (b2.STAT_ERR_CNT !== 16'd0) begin n_bad++; $display("FAIL w128_err got %0h want 0", b2.STAT_ERR_CNT); end
  endtask

  initial begin
    b.DFK_CP_SOP = 1'b0;  b.DFK_CP_EOP = 1'b0;  b.DFK_CP_DVLD = 1'b0;
    b.DFK_CP_DATA = '0;   b.DFK_CP_TAG = 8'h0;  b.DFK_CP_DCNT = 12'h0;
    b.DN_FILE_RDY = 1'b0;
    b2.DFK_CP_SOP = 1'b0; b2.DFK_CP_EOP = 1'b0; b2.DFK_CP_DVLD = 1'b0;
    b2.DFK_CP_DATA = '0;  b2.DFK_CP_TAG = 8'h0; b2.DFK_CP_DCNT = 12'h0;
    b2.DN_FILE_RDY = 1'b0;
    test_reset();
    test_single();
    test_group();
    test_hdr_ovf();
    test_errors();
    test_reset_mid();
    test_dw128();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pcie_dn_cpld_dfk_mc.md
Name: pcie_dn_cpld_dfk_mc

Overview:
Parametrised, multi-channel successor of the downstream descriptor-completion unpacker. Assembles 256-bit descriptors from CplD beats of width DW, with a separate assembly context per channel selected by tag. Extracts free-buffer entries and file headers. Buffers file headers in a ready/valid FIFO. Generates per-channel grouped RD_REQ/RD_ACK pulses and counts malformed completions and header overflows.
Sits between the PCIe RX completion demux and the downstream file/buffer manager.

Parameters:
DW, 64, CplD data width in bits; legal values 64, 128, 256; BEATS = 256/DW.
NCH, 4, number of channels, 1..8; channel = DFK_CP_TAG[CHW-1:0], with CHW = max(1, clog2(NCH)).
DESC_PER_ACK, 8, descriptors per RD_ACK group, power of 2, 2..64.
ACK_DLY, 4, pipeline stages on RD_REQ/RD_ACK/RD_CH, 1..8.
HDR_DEPTH, 4, file-header FIFO depth, power of 2, 2..16.

Ports:
PCIE_CLK  in  1  clock
PCIE_RST_N  in  1  asynchronous active-low reset
DFK_CP_SOP  in  1  first beat of a completion
DFK_CP_EOP  in  1  last beat of a completion
DFK_CP_DATA  in  DW  completion payload beat
DFK_CP_DVLD  in  1  beat valid
DFK_CP_TAG  in  8  tag; low CHW bits select the channel
DFK_CP_DCNT  in  12  DW count of the completion; informational, unused for assembly
DN_FBUF_WR_REQ  out  1  free-buffer entry valid, 1-cycle pulse
DN_FBUF_WR_DATA  out  96  {desc[111:96], desc[79:64], desc[63:0]}
DN_FBUF_WR_CH  out  CHW  channel of the WR entry
DN_FBUF_RD_REQ  out  1  group read request pulse
DN_FBUF_RD_ACK  out  1  group acknowledge pulse
DN_FBUF_RD_CH  out  CHW  channel of the RD pulses
DN_FILE_VLD  out  1  header FIFO head valid
DN_FILE_RDY  in  1  consumer ready
DN_FILE_SOF  out  1  desc[127]
DN_FILE_EOF  out  1  desc[126]
DN_FILE_FID  out  16  desc[159:144]
DN_FILE_SID  out  16  desc[143:128]
DN_FILE_VCH  out  16  desc[95:80]
DN_FILE_ADDR  out  32  desc[223:192]
DN_FILE_SIZE  out  32  desc[191:160]
DN_FILE_CH  out  CHW  channel of the header
STAT_ERR_CNT  out  16  malformed-descriptor count, saturating
STAT_OVF_CNT  out  16  dropped-header count, saturating

Behaviour:
- Reset (PCIE_RST_N=0, asynchronous): every output, assembly register, beat counter, group counter, delay stage, FIFO pointer and statistic counter is cleared to 0. An in-flight partial descriptor is discarded with no error count.
- Assembly, per channel:
  - Each channel has a 256-bit shift register and a beat counter of width clog2(BEATS)+1.
  - A beat on channel c is accepted when DVLD=1. The shift register shifts right by DW and inserts the beat at the top, so the first beat lands in desc[DW-1:0].
  - SOP with DVLD=1 forces the beat counter to 1, as this beat is the first. If the counter was non-zero, that is an error.
  - Descriptor complete when an accepted beat makes the counter equal BEATS; the counter then returns to 0. A completion may carry several descriptors back to back.
  - Error case 1: EOP on a beat that does not complete a descriptor. The partial descriptor is discarded, the counter is cleared, and STAT_ERR_CNT increments by 1.
  - Error case 2: SOP while the counter is non-zero. Same handling: partial discarded, counter restarted, STAT_ERR_CNT +1.
  - Both error cases on one beat count once.
  - DW=256: every beat is a complete descriptor.
- Pipeline:
  - The completing beat is sampled at edge E0; the descriptor register is valid after E0.
  - At edge E1: WR_REQ = desc[120], WR_DATA and WR_CH are registered, and a header push occurs if desc[127]|desc[126].
  - WR_DATA and WR_CH hold their last value while WR_REQ=0.
- Header FIFO:
  - First-word fall-through. DN_FILE_VLD=1 when non-empty; pop on VLD&RDY.
  - Push while full with no pop in the same cycle: the header is dropped and STAT_OVF_CNT increments by 1.
  - Push and pop in the same cycle when full: accepted.
  - The header is visible in the cycle after E1 when the FIFO was empty.
  - Data outputs hold the head value; their value while VLD=0 is don't-care.
- Grouping:
  - Each channel has a counter mod DESC_PER_ACK, incremented on each complete descriptor regardless of desc[120].
  - On a descriptor that completes a group (counter = DESC_PER_ACK-1), at E1 set ack_stage0=1, req_stage0=desc[121], ch_stage0=c; the counter wraps to 0.
  - Outputs are taken from stage ACK_DLY-1, i.e. they occur ACK_DLY-1 cycles after WR_REQ of the same descriptor.
  - Other channels' counters are unaffected.
- Throughput: one beat per cycle sustained. Beats for different channels may interleave cycle by cycle. At most one descriptor completes per cycle.
- Statistic counters saturate at 0xFFFF.

Test Plan:
- DW=64, NCH=4, tag=0x02: 4 beats with SOP on beat 0 and EOP on beat 3, desc[120]=1, desc[63:0]=0x1122334455667788 -> WR_REQ pulse 2 cycles after beat 3, WR_CH=2, WR_DATA[63:0]=0x1122334455667788, no header, STAT_ERR_CNT=0.
- 8 descriptors on channel 1 with desc[121]=1 on the 8th only -> single RD_ACK+RD_REQ pulse with RD_CH=1, 3 cycles after the 8th WR_REQ. Channel 0 receiving 7 descriptors interleaved yields no RD pulse.
- 5 headers (desc[127]=1, FID=0x00A0..0x00A4) with DN_FILE_RDY=0 -> 4 stored, STAT_OVF_CNT=1. Raising RDY pops FIDs 0x00A0..0x00A3 in order, then VLD=0.
- EOP after 2 beats on channel 3, then a full 4-beat completion -> STAT_ERR_CNT=1, exactly one WR_REQ, data from the second completion only.
- 3 of 4 beats sent, assert PCIE_RST_N=0 mid-cycle -> all outputs 0 immediately. After release, a fresh 4-beat descriptor is assembled correctly and STAT_ERR_CNT=0.
- DW=128, NCH=1: 2-beat descriptor with SIZE=0x00001000, ADDR=0x80000000, desc[126]=1 -> DN_FILE_VLD with EOF=1, SIZE=0x00001000, ADDR=0x80000000.
